stopwatch_bcd_counter: RTL
==========================

Name: stopwatch_bcd_counter

Overview:
Timekeeping core of the stopwatch. It counts elapsed time as four BCD digits (MM:SS, 00:00 to 59:59), driven by an internal prescaler derived from the system clock. It sits directly upstream of the BCD-to-binary converters, which consume each digit, and downstream of the debounced button logic. It also provides a lap-hold function: the displayed time freezes while counting continues.

Parameters:
TICKS_PER_SEC, 10_000_000, clk cycles per counted second; must be >= 2.
PRESCALE_W, $clog2(TICKS_PER_SEC), prescaler counter width.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start_stop  input  1  single-cycle pulse (already debounced); toggles run/pause
clear  input  1  single-cycle pulse; zero the time and go to IDLE
lap  input  1  single-cycle pulse; toggles lap hold of the displayed digits
sec_ones  output  4  BCD seconds units, 0-9
sec_tens  output  4  BCD seconds tens, 0-5
min_ones  output  4  BCD minutes units, 0-9
min_tens  output  4  BCD minutes tens, 0-5
running  output  1  1 while the state is RUNNING
lap_hold  output  1  1 while the displayed digits are frozen
wrap  output  1  one-cycle pulse when the count rolls over from 59:59 to 00:00

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; prescaler=0.
  - All live and snapshot digits = 0.
  - running=0, lap_hold=0, wrap=0.
- States:
  - IDLE: count is zero.
  - RUNNING: counting.
  - PAUSED: count frozen, nonzero or zero.
- Transitions, evaluated at each clk edge on registered state and inputs:
  - IDLE + start_stop -> RUNNING.
  - RUNNING + start_stop -> PAUSED.
  - PAUSED + start_stop -> RUNNING.
  - Any state + clear -> IDLE.
- clear has priority over start_stop and lap in the same cycle. It also:
  - zeroes the prescaler and all live and snapshot digits;
  - forces lap_hold=0.
- Prescaler:
  - Increments only on edges where state==RUNNING.
  - At TICKS_PER_SEC-1 it returns to 0 and generates an internal sec_tick in that same edge.
  - Holds its value in PAUSED, so sub-second progress is preserved across a pause.
- Latency: a start_stop pulse sampled at edge k gives running=1 after edge k. The first sec_ones increment is visible after edge k+TICKS_PER_SEC.
- Digit chain on sec_tick:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 carries into min_tens.
  - min_tens 5->0 at 59:59 gives 00:00 and wrap=1 for exactly one cycle; counting continues in RUNNING.
- Digits are never outside their legal BCD range. Arithmetic is per digit, 4 bits, with no binary intermediate.
- start_stop arriving in the same edge as sec_tick in RUNNING: the tick is applied and the state goes to PAUSED.
- Lap:
  - lap in RUNNING or PAUSED toggles lap_hold.
  - On the 0->1 toggle edge, the snapshot registers load the live digits as they are after that edge's update (including any simultaneous tick).
  - lap in IDLE is ignored.
- Outputs:
  - Each digit output = lap_hold ? snapshot : live.
  - Both sources are registers; the 2:1 mux is the only logic between them and the outputs.
  - running, lap_hold and wrap are registered.

Decomposition:
- Package stopwatch_pkg:
  - typedef bcd_digit_t (logic [3:0]);
  - enum sw_state_t {IDLE, RUNNING, PAUSED};
  - constants DIGIT_MAX_UNITS=9 and DIGIT_MAX_TENS=5.
- Sub-module bcd_digit_counter:
  - parameter MAX;
  - inputs clk, rst_n, clr, inc;
  - outputs digit and carry (carry = inc && digit==MAX);
  - instantiated 4x, chained via carry.

Test Plan:
1. Reset mid-count, TICKS_PER_SEC=4: run to 00:07, pulse rst_n low asynchronously between edges -> all outputs 0 immediately, state IDLE; the following start_stop restarts from 00:00.
2. Basic count: start_stop at edge 0 -> running=1 after edge 0; sec_ones=1 after edge 4, =9 after edge 36; 00:10 after edge 40.
3. Pause/resume with partial prescale:
   - Stop at edge 6 (prescaler=2, 00:01); hold 20 cycles -> digits unchanged.
   - Resume at edge 26 -> 00:02 after edge 28 (2 remaining ticks), not after edge 30.
4. Rollover:
   - Run to 59:59 -> next sec_tick gives 00:00 with wrap=1 for one cycle; running stays 1.
   - 59:09 -> 59:10 and 09:59 -> 10:00 carries correct.
5. Lap:
   - At 00:03, pulse lap -> outputs frozen at 00:03 and lap_hold=1; live count continues.
   - Pulse lap at live 00:08 -> outputs show 00:08, lap_hold=0.
   - lap in IDLE -> no change.
6. Priority: clear+start_stop+lap in the same cycle while RUNNING at 00:05 -> IDLE, 00:00, running=0, lap_hold=0, prescaler 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
// Includes the per-digit BCD step used by counters and lap snapshot.
package stopwatch_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    localparam bcd_digit_t DIGIT_MAX_UNITS = 4'd9;
    localparam bcd_digit_t DIGIT_MAX_TENS  = 4'd5;

    function automatic bcd_digit_t bcd_next(
        input bcd_digit_t d,
        input logic       inc,
        input bcd_digit_t max
    );
        bcd_digit_t r;
        r = d;
        if (inc) begin
            r = (d == max) ? 4'd0 : d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_digit.sv
// Single BCD digit, 0..MAX, with synchronous clear and ripple carry.
// Carry is combinational so a chain advances within one edge.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_digit_t MAX = DIGIT_MAX_UNITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t digit,
    output logic       carry
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = bcd_next(digit_q, inc, MAX);
        if (clr) begin
            digit_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc && (digit_q == MAX);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS stopwatch core: prescaler, run/pause FSM, BCD chain, lap hold.
// Displayed digits come from live or snapshot registers via a 2:1 mux.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10_000_000,
    parameter int PRESCALE_W    = $clog2(TICKS_PER_SEC)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output bcd_digit_t sec_ones,
    output bcd_digit_t sec_tens,
    output bcd_digit_t min_ones,
    output bcd_digit_t min_tens,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap
);

    localparam logic [PRESCALE_W-1:0] PRESC_LAST =
        PRESCALE_W'(TICKS_PER_SEC - 1);

    sw_state_t state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    bcd_digit_t [3:0] snap_q, snap_d;
    bcd_digit_t [3:0] live;
    bcd_digit_t [3:0] live_next;
    logic [4:0] chain;
    logic lap_hold_q, lap_hold_d;
    logic running_q, running_d;
    logic wrap_q, wrap_d;
    logic sec_tick;
    logic lap_ok;

    assign sec_tick = (state_q == RUNNING) && (presc_q == PRESC_LAST) && !clear;
    assign chain[0] = sec_tick;

    // Digit 0 = sec_ones ... digit 3 = min_tens; even digits count to 9.
    for (genvar i = 0; i < 4; i++) begin : g_digit
        localparam bcd_digit_t MX =
            (i % 2 == 0) ? DIGIT_MAX_UNITS : DIGIT_MAX_TENS;
        bcd_digit_counter #(.MAX(MX)) u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clear),
            .inc   (chain[i]),
            .digit (live[i]),
            .carry (chain[i+1])
        );
        assign live_next[i] = bcd_next(live[i], chain[i], MX);
    end

    assign lap_ok = lap && !clear && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        if (start_stop) begin
            unique case (state_q)
                IDLE:    state_d = RUNNING;
                RUNNING: state_d = PAUSED;
                PAUSED:  state_d = RUNNING;
                default: state_d = IDLE;
            endcase
        end
        if (clear) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (state_q == RUNNING) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    // Snapshot captures the post-update live value on the hold-entry edge.
    always_comb begin
        lap_hold_d = lap_hold_q;
        snap_d     = snap_q;
        if (clear) begin
            lap_hold_d = 1'b0;
            snap_d     = '0;
        end else if (lap_ok) begin
            lap_hold_d = !lap_hold_q;
            if (!lap_hold_q) begin
                snap_d = live_next;
            end
        end
    end

    assign running_d = (state_d == RUNNING);
    assign wrap_d    = chain[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            snap_q     <= '0;
            lap_hold_q <= 1'b0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            snap_q     <= snap_d;
            lap_hold_q <= lap_hold_d;
            running_q  <= running_d;
            wrap_q     <= wrap_d;
        end
    end

    assign sec_ones = lap_hold_q ? snap_q[0] : live[0];
    assign sec_tens = lap_hold_q ? snap_q[1] : live[1];
    assign min_ones = lap_hold_q ? snap_q[2] : live[2];
    assign min_tens = lap_hold_q ? snap_q[3] : live[3];
    assign running  = running_q;
    assign lap_hold = lap_hold_q;
    assign wrap     = wrap_q;

endmodule
